// File: rtl/segment_integrator.sv
// Integrates per-frame segment visibility over a fixed window of frames and
// thresholds each segment's hit count to recover the message segment vector.
//
// state  | meaning
// IDLE   | waiting for start; frames ignored
// ACCUM  | accepting frames, counting hits per segment
// DECIDE | one cycle: threshold hit counts into msg
// HOLD   | msg_valid high until the consumer takes the message
module segment_integrator #(
  parameter int NB_SEGMENTS = 14,
  parameter int NB_FRAMES   = 16,
  parameter int THRESHOLD   = 8,
  parameter int CNT_W       = $clog2(NB_FRAMES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  input  logic [NB_SEGMENTS-1:0] frame_seg,
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic [NB_SEGMENTS-1:0] msg,
  output logic                   busy,
  output logic [CNT_W-1:0]       frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       hit [NB_SEGMENTS];
  logic                   clr;
  logic                   accept;
  logic                   load_msg;
  logic [NB_SEGMENTS-1:0] msg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort overrides every transition, including start in IDLE
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    accept    = 1'b0;
    load_msg  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      clr       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            clr       = 1'b1;
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (frame_valid) begin
            accept = 1'b1;
            if (frame_cnt == CNT_W'(NB_FRAMES - 1)) state_nxt = DECIDE;
          end
        end
        DECIDE: begin
          load_msg  = 1'b1;
          state_nxt = HOLD;
        end
        HOLD: begin
          if (msg_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (clr) begin
      frame_cnt <= '0;
    end else if (accept) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB_SEGMENTS; i++) hit[i] <= '0;
    end else begin
      for (int i = 0; i < NB_SEGMENTS; i++) begin
        if (clr)                         hit[i] <= '0;
        else if (accept && frame_seg[i]) hit[i] <= hit[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    msg_d = '0;
    for (int i = 0; i < NB_SEGMENTS; i++) msg_d[i] = (hit[i] >= CNT_W'(THRESHOLD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        msg <= '0;
    else if (load_msg) msg <= msg_d;
  end

  assign frame_ready = (state == ACCUM);
  assign msg_valid   = (state == HOLD);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_segment_integrator.sv
// Bench for segment_integrator: behavioural window/threshold model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_segment_integrator;

  localparam int NS  = 14;
  localparam int NF  = 16;
  localparam int TH  = 8;
  localparam int CW  = $clog2(NF + 1);

  logic          clk, rst_n;
  logic          start, abort, frame_valid, msg_ready;
  logic [NS-1:0] frame_seg;
  logic          frame_ready, msg_valid, busy;
  logic [NS-1:0] msg;
  logic [CW-1:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  segment_integrator #(.NB_SEGMENTS(NS), .NB_FRAMES(NF), .THRESHOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_seg(frame_seg),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg(msg),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting, 2 deciding, 3 presenting
  int            m_phase;
  int            m_hits [NS];
  int            m_frames;
  logic [NS-1:0] m_msg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_frames = 0; m_msg = '0;
      for (int i = 0; i < NS; i++) m_hits[i] = 0;
    end else if (abort) begin
      m_phase = 0; m_frames = 0;
      for (int i = 0; i < NS; i++) m_hits[i] = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_frames = 0;
        for (int i = 0; i < NS; i++) m_hits[i] = 0;
      end
    end else if (m_phase == 1) begin
      if (frame_valid) begin
        m_frames++;
        for (int i = 0; i < NS; i++) m_hits[i] += int'(frame_seg[i]);
        if (m_frames == NF) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      for (int i = 0; i < NS; i++) m_msg[i] = (m_hits[i] >= TH);
      m_phase = 3;
    end else if (msg_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("frame_ready", 32'(frame_ready), 32'(m_phase == 1));
      check("busy",        32'(busy),        32'(m_phase != 0));
      check("msg_valid",   32'(msg_valid),   32'(m_phase == 3));
      check("msg",         32'(msg),         32'(m_msg));
      check("frame_cnt",   32'(frame_cnt),   32'(m_frames));
    end
  end

  task automatic step(input logic s, input logic a, input logic fv,
                      input logic [NS-1:0] seg, input logic mr);
    start = s; abort = a; frame_valid = fv; frame_seg = seg; msg_ready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic send_frame(input logic [NS-1:0] seg);
    int  n;
    logic acc;
    n = 0;
    forever begin
      acc = frame_ready;
      step(1'b0, 1'b0, 1'b1, seg, 1'b0);
      if (acc) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_frame timeout: frame_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
  endtask

  logic [NS-1:0] seg, saved;
  int            acc_cnt, guard;

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; frame_valid = 0; frame_seg = '0; msg_ready = 0;
    #23;
    check("reset frame_ready", 32'(frame_ready), 32'd0);
    check("reset msg_valid",   32'(msg_valid),   32'd0);
    check("reset msg",         32'(msg),         32'd0);
    check("reset busy",        32'(busy),        32'd0);
    check("reset frame_cnt",   32'(frame_cnt),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all segments lit every frame; latency of 2 cycles to msg_valid
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("start frame_ready", 32'(frame_ready), 32'd1);
    check("start busy",        32'(busy),        32'd1);
    for (int k = 0; k < NF; k++) send_frame(14'h3FFF);
    check("decide msg_valid",   32'(msg_valid),   32'd0);
    check("decide frame_ready", 32'(frame_ready), 32'd0);
    check("decide frame_cnt",   32'(frame_cnt),   32'd16);
    idle();
    check("all-lit msg_valid", 32'(msg_valid), 32'd1);
    check("all-lit msg",       32'(msg),       32'h3FFF);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("release msg_valid", 32'(msg_valid), 32'd0);
    check("release busy",      32'(busy),      32'd0);

    // threshold boundary on segments 0..2
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < NF; k++) begin
      seg = NS'($urandom());
      seg[0] = (k < 8);
      seg[1] = (k < 7);
      seg[2] = 1'b0;
      send_frame(seg);
    end
    idle();
    saved = msg;
    check("threshold msg[2:0]", 32'(saved[2:0]), 32'd1);

    // stall in HOLD with start pulses that must be ignored
    for (int k = 0; k < 10; k++) begin
      step(k % 3 == 0, 1'b0, 1'b0, '0, 1'b0);
      check("hold msg_valid", 32'(msg_valid), 32'd1);
      check("hold msg",       32'(msg),       32'(saved));
    end
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("hold exit msg_valid", 32'(msg_valid), 32'd0);

    // back-pressure: random gaps on frame_valid
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    acc_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (frame_ready && frame_valid) acc_cnt++;
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), NS'($urandom()), 1'b0);
    end
    guard = 0;
    while (!msg_valid && guard < 40) begin
      step(1'b0, 1'b0, 1'b1, NS'($urandom()), 1'b0);
      guard++;
    end
    check("backpressure msg_valid", 32'(msg_valid), 32'd1);
    check("backpressure frame_cnt", 32'(frame_cnt), 32'd16);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // abort after 5 frames, then a clean window of segment 0 only
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 5; k++) send_frame(14'h3FFF);
    check("pre-abort frame_cnt", 32'(frame_cnt), 32'd5);
    step(1'b0, 1'b1, 1'b1, 14'h3FFF, 1'b0);
    check("abort frame_cnt", 32'(frame_cnt), 32'd0);
    check("abort busy",      32'(busy),      32'd0);
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("abort+start busy", 32'(busy), 32'd0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < NF; k++) send_frame(14'h0001);
    idle();
    check("after-abort msg", 32'(msg), 32'h0001);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);

    // asynchronous reset between edges mid-window
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) send_frame(14'h00FF);
    #2 rst_n = 1'b0;
    #1;
    check("async frame_ready", 32'(frame_ready), 32'd0);
    check("async busy",        32'(busy),        32'd0);
    check("async frame_cnt",   32'(frame_cnt),   32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rel msg",       32'(msg),       32'd0);
    check("rel msg_valid", 32'(msg_valid), 32'd0);
    check("rel busy",      32'(busy),      32'd0);

    // randomized traffic, model checks every cycle
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 7, NS'($urandom()), $urandom_range(0, 2) == 0);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
